// File: rtl/key_unlock_sequencer.sv
// rtl/key_unlock_sequencer.sv - byte-serial 64-bit key loader that holds the core in reset until a key is committed
// Optional trailing checksum byte enabled by KEY_UNLOCK_CHECKSUM_EN.
module key_unlock_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RST_HOLD       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [63:0] key,
    output logic        key_valid,
    output logic        core_rst,
    output logic        busy,
    output logic        error
);

`ifdef KEY_UNLOCK_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [3:0] LAST_BYTE = 4'd7;
`endif
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [63:0] shadow_q;
    logic [63:0] key_q;
    logic [3:0]  byte_cnt_q;
    logic [15:0] tmo_cnt_q;
    logic [15:0] hold_cnt_q;
    logic        key_valid_q;
    logic        core_rst_q;
    logic        byte_ready_q;
    logic        busy_q;
    logic        error_q;
`ifdef KEY_UNLOCK_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic accept_d;
    logic start_ok_d;
    logic check_pass_d;

    function automatic logic [7:0] fold_xor(input logic [63:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ v[i*8 +: 8];
        end
        return acc;
    endfunction

    // byte_ready_q is only ever high in LOAD, so it doubles as the state qualifier
    always_comb begin
        accept_d   = byte_valid && byte_ready_q;
        start_ok_d = load_start &&
                     ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERR));
`ifdef KEY_UNLOCK_CHECKSUM_EN
        check_pass_d = (fold_xor(shadow_q) == csum_q);
`else
        check_pass_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shadow_q     <= 64'h0;
            key_q        <= 64'h0;
            byte_cnt_q   <= 4'd0;
            tmo_cnt_q    <= 16'd0;
            hold_cnt_q   <= 16'd0;
            key_valid_q  <= 1'b0;
            core_rst_q   <= 1'b1;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef KEY_UNLOCK_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else if (start_ok_d) begin
            state_q      <= S_LOAD;
            shadow_q     <= 64'h0;
            key_q        <= 64'h0;
            byte_cnt_q   <= 4'd0;
            tmo_cnt_q    <= 16'd0;
            key_valid_q  <= 1'b0;
            core_rst_q   <= 1'b1;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
`ifdef KEY_UNLOCK_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    // An accept on the would-be timeout cycle wins over the error
                    if (accept_d) begin
`ifdef KEY_UNLOCK_CHECKSUM_EN
                        if (byte_cnt_q == LAST_BYTE) begin
                            csum_q <= byte_data;
                        end else begin
                            shadow_q <= {shadow_q[55:0], byte_data};
                        end
`else
                        shadow_q <= {shadow_q[55:0], byte_data};
`endif
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        tmo_cnt_q  <= 16'd0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_q      <= S_CHECK;
                            byte_ready_q <= 1'b0;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q      <= S_ERR;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (check_pass_d) begin
                        state_q     <= S_HOLD;
                        key_q       <= shadow_q;
                        key_valid_q <= 1'b1;
                        hold_cnt_q  <= 16'd0;
                    end else begin
                        state_q <= S_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= S_RUN;
                        core_rst_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule
